// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: scans a 4x4 active-low key matrix one row per scan tick,
// debounces press and release over DEBOUNCE_TICKS ticks, and reports the
// accepted key as row*4+col with a one-clock key_valid pulse.

module keypad_scanner_4x4 #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [23:0] DIV_LAST = 24'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_TICKS = 4'(DEBOUNCE_TICKS);

  logic [3:0]  col_meta;
  logic [3:0]  col_s;
  logic [23:0] presc;
  logic        tick;
  state_t      state;
  logic [1:0]  r;
  logic [1:0]  c;
  logic [3:0]  cnt;
  logic        any_low;
  logic [1:0]  low_idx;
  logic        sel_low;

  // Active-low row drive pattern for a given row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

  // Two-flop synchronizer for the asynchronous column lines; idles at all-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta <= 4'b1111;
      col_s    <= 4'b1111;
    end else begin
      col_meta <= COL;
      col_s    <= col_meta;
    end
  end

  // Scan prescaler: one tick every SCAN_DIV clocks, first tick SCAN_DIV clocks after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 24'd1;
    end
  end

  assign tick = (presc == DIV_LAST);

  // Lowest-index pressed column wins when several columns read low together.
  always_comb begin
    any_low = ~&col_s;
    low_idx = 2'd0;
    if (!col_s[0]) begin
      low_idx = 2'd0;
    end else if (!col_s[1]) begin
      low_idx = 2'd1;
    end else if (!col_s[2]) begin
      low_idx = 2'd2;
    end else if (!col_s[3]) begin
      low_idx = 2'd3;
    end
  end

  // Only the latched column matters once a candidate key has been found.
  assign sel_low = ~col_s[c];

  // Scan/debounce/hold/release controller; all decisions happen on ticks,
  // while key_valid is cleared every clock so it can only ever pulse once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      r         <= 2'd0;
      c         <= 2'd0;
      cnt       <= 4'd0;
      ROW       <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              c <= low_idx;
              if (DB_TICKS == 4'd1) begin
                key_code  <= {r, low_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= 4'd0;
                state     <= HELD;
              end else begin
                cnt   <= 4'd1;
                state <= DEBOUNCE;
              end
            end else begin
              r   <= r + 2'd1;
              ROW <= row_drive(r + 2'd1);
            end
          end
          DEBOUNCE: begin
            if (sel_low) begin
              if (cnt + 4'd1 == DB_TICKS) begin
                key_code  <= {r, c};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= 4'd0;
                state     <= HELD;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              cnt   <= 4'd0;
              r     <= r + 2'd1;
              ROW   <= row_drive(r + 2'd1);
              state <= SCAN;
            end
          end
          HELD: begin
            if (!sel_low) begin
              if (DB_TICKS == 4'd1) begin
                key_held <= 1'b0;
                cnt      <= 4'd0;
                r        <= r + 2'd1;
                ROW      <= row_drive(r + 2'd1);
                state    <= SCAN;
              end else begin
                cnt   <= 4'd1;
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (sel_low) begin
              cnt   <= 4'd0;
              state <= HELD;
            end else if (cnt + 4'd1 == DB_TICKS) begin
              key_held <= 1'b0;
              cnt      <= 4'd0;
              r        <= r + 2'd1;
              ROW      <= row_drive(r + 2'd1);
              state    <= SCAN;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4: drives a simulated key matrix into the scanner and
// compares every cycle against a tick-level behavioural model, plus literal checks.

module tb_keypad_scanner_4x4;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0000;

  int checks = 0;
  int failures = 0;
  int pulse_count = 0;
  int pulse_mark;

  // Behavioural model state: synchronizer copies, tick phase, scan row,
  // locked column (-1 when scanning), run length of agreeing ticks.
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  int         m_phase = 0;
  int         m_row = 0;
  int         m_lock = -1;
  int         m_run = 0;
  int         m_first;
  bit         m_acc = 1'b0;
  logic [3:0] m_code = 4'h0;
  bit         m_valid = 1'b0;
  bit         m_held = 1'b0;
  bit         model_valid = 1'b0;
  logic [3:0] exp_row;

  always #5 clk = ~clk;

  keypad_scanner_4x4 #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_TICKS(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .COL(col),
    .ROW(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // Physical keypad: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col = 4'hF;
    for (int rr = 0; rr < 4; rr++) begin
      for (int cc = 0; cc < 4; cc++) begin
        if (pressed[rr*4+cc] && (row[rr] == 1'b0)) col[cc] = 1'b0;
      end
    end
  end

  // Tick-level model: on each tick decide from the synchronized columns what the
  // scanner must report, then age the synchronizer copies by one clock.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_row = 0; m_lock = -1; m_run = 0; m_acc = 1'b0;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
      m_s1 = 4'hF; m_s2 = 4'hF;
      model_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_phase == SCAN_DIV - 1) begin
        if (m_lock < 0) begin
          m_first = -1;
          for (int i = 3; i >= 0; i--) if (!m_s2[i]) m_first = i;
          if (m_first >= 0) begin
            m_lock = m_first;
            m_run = 1;
            if (m_run == DB) begin
              m_code = 4'(m_row * 4 + m_lock); m_valid = 1'b1; m_held = 1'b1; m_acc = 1'b1; m_run = 0;
            end
          end else begin
            m_row = (m_row + 1) % 4;
          end
        end else if (!m_acc) begin
          if (!m_s2[m_lock]) begin
            m_run++;
            if (m_run == DB) begin
              m_code = 4'(m_row * 4 + m_lock); m_valid = 1'b1; m_held = 1'b1; m_acc = 1'b1; m_run = 0;
            end
          end else begin
            m_lock = -1; m_run = 0; m_row = (m_row + 1) % 4;
          end
        end else begin
          if (m_s2[m_lock]) begin
            m_run++;
            if (m_run == DB) begin
              m_held = 1'b0; m_acc = 1'b0; m_lock = -1; m_run = 0; m_row = (m_row + 1) % 4;
            end
          end else begin
            m_run = 0;
          end
        end
      end
      m_phase = (m_phase + 1) % SCAN_DIV;
      m_s2 = m_s1;
      m_s1 = col;
    end
    exp_row = 4'hF ^ (4'(1) << m_row);
  end

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check_output("model_row", {4'h0, row}, {4'h0, exp_row});
      check_output("model_key_code", {4'h0, key_code}, {4'h0, m_code});
      check_output("model_key_valid", {7'h0, key_valid}, {7'h0, m_valid});
      check_output("model_key_held", {7'h0, key_held}, {7'h0, m_held});
    end
  end

  // Pulse counter for press-count checks.
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_count++;
  end

  // Align to the negedge right after a tick edge.
  task automatic wait_boundary();
    int guard;
    guard = 0;
    while (m_phase != 0 && guard < 2 * SCAN_DIV) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] keys, input int ticks);
    wait_boundary();
    pressed = keys;
    repeat (ticks * SCAN_DIV) @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle scan: ROW steps every SCAN_DIV clocks, first step SCAN_DIV clocks after reset.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0)  check_output("reset_key_code", {4'h0, key_code}, 8'h00);
      if (k == 2)  check_output("idle_row_k2", {4'h0, row}, 8'h0E);
      if (k == 3)  check_output("idle_row_k3", {4'h0, row}, 8'h0D);
      if (k == 7)  check_output("idle_row_k7", {4'h0, row}, 8'h0B);
      if (k == 11) check_output("idle_row_k11", {4'h0, row}, 8'h07);
      if (k == 15) check_output("idle_row_k15", {4'h0, row}, 8'h0E);
    end
    check_output("idle_no_pulse", 8'(pulse_count), 8'd0);

    // Bounced press of row2/col1: two low ticks then a high tick must not accept.
    for (int t = 0; t < 8 && m_row != 2; t++) apply_stimulus(16'h0000, 1);
    pulse_mark = pulse_count;
    apply_stimulus(16'h0200, 2);
    apply_stimulus(16'h0000, 1);
    check_output("bounce_no_pulse", 8'(pulse_count - pulse_mark), 8'd0);
    check_output("bounce_not_held", {7'h0, key_held}, 8'h00);

    // Steady press afterwards: exactly one acceptance with code 9 and frozen row.
    apply_stimulus(16'h0200, 12);
    check_output("press9_pulses", 8'(pulse_count - pulse_mark), 8'd1);
    check_output("press9_code", {4'h0, key_code}, 8'h09);
    check_output("press9_held", {7'h0, key_held}, 8'h01);
    check_output("press9_row", {4'h0, row}, 8'h0B);

    // Long hold plus extra keys on the same and other rows: still only one pulse.
    apply_stimulus(16'h0300, 10);
    apply_stimulus(16'h2200, 10);
    apply_stimulus(16'h0200, 4);
    check_output("hold_one_pulse", 8'(pulse_count - pulse_mark), 8'd1);
    check_output("hold_code", {4'h0, key_code}, 8'h09);
    check_output("hold_row", {4'h0, row}, 8'h0B);

    // Bounced release: high 2 ticks, low 1, high 3.
    pulse_mark = pulse_count;
    apply_stimulus(16'h0000, 2);
    check_output("rel_held_a", {7'h0, key_held}, 8'h01);
    apply_stimulus(16'h0200, 1);
    check_output("rel_held_b", {7'h0, key_held}, 8'h01);
    apply_stimulus(16'h0000, 2);
    check_output("rel_held_c", {7'h0, key_held}, 8'h01);
    apply_stimulus(16'h0000, 1);
    check_output("rel_done_held", {7'h0, key_held}, 8'h00);
    check_output("rel_done_row", {4'h0, row}, 8'h07);
    check_output("rel_no_pulse", 8'(pulse_count - pulse_mark), 8'd0);
    check_output("rel_code_kept", {4'h0, key_code}, 8'h09);

    // Two keys on row0, cols 0 and 2: column 0 wins, code 0.
    pulse_mark = pulse_count;
    apply_stimulus(16'h0005, 12);
    check_output("dual02_code", {4'h0, key_code}, 8'h00);
    check_output("dual02_pulses", 8'(pulse_count - pulse_mark), 8'd1);
    apply_stimulus(16'h0000, 5);
    check_output("dual02_released", {7'h0, key_held}, 8'h00);

    // Two keys on row0, cols 1 and 3: column 1 wins, code 1.
    pulse_mark = pulse_count;
    apply_stimulus(16'h000A, 12);
    check_output("dual13_code", {4'h0, key_code}, 8'h01);
    check_output("dual13_held", {7'h0, key_held}, 8'h01);
    check_output("dual13_pulses", 8'(pulse_count - pulse_mark), 8'd1);

    // Reset while held: everything back to reset values.
    pulse_mark = pulse_count;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_code", {4'h0, key_code}, 8'h00);
    check_output("rst_held", {7'h0, key_held}, 8'h00);
    check_output("rst_valid", {7'h0, key_valid}, 8'h00);
    check_output("rst_row", {4'h0, row}, 8'h0E);
    pressed = 16'h0000;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("post_rst_row_a", {4'h0, row}, 8'h0E);
    @(negedge clk);
    check_output("post_rst_row_b", {4'h0, row}, 8'h0D);
    repeat (8) @(negedge clk);
    check_output("post_rst_no_pulse", 8'(pulse_count - pulse_mark), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
